// File: rtl/mem_bank_b_read_gen_pkg.sv
// Shared matrix-multiplier definitions: bank B reader FSM states and tile helpers.
package mem_bank_b_read_gen_pkg;

   localparam int DIM_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CHECK,
      ST_STREAM,
      ST_DRAIN
   } rd_state_e;

   function automatic logic [DIM_W-1:0] ceil_tiles(input logic [DIM_W-1:0] x, input int unsigned d);
      logic [31:0] t;
      t = (32'(x) + 32'(d) - 32'd1) / 32'(d);
      return t[DIM_W-1:0];
   endfunction

   function automatic logic [DIM_W-1:0] floor_tiles(input logic [DIM_W-1:0] x, input int unsigned d);
      logic [31:0] t;
      t = 32'(x) / 32'(d);
      return t[DIM_W-1:0];
   endfunction

endpackage

// File: rtl/mem_bank_b_read_gen_tile_counter.sv
// Wrapping tile counter: counts 0..limit-1 on en, carry-out pulses on the wrapping step.
module mem_bank_b_read_gen_tile_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] limit,
   output logic         wrap_o
);

   logic [W-1:0] r_count;

   assign wrap_o = en && (r_count == limit - W'(1));

   always_ff @(posedge clk) begin
      if (!reset_n || clr) begin
         r_count <= '0;
      end else if (en) begin
         r_count <= wrap_o ? '0 : r_count + W'(1);
      end
   end

endmodule

// File: rtl/mem_bank_b_read_gen.sv
// Bank B read generator: streams B words (k fastest, then column tile j, then A row tile i)
// to the array feeder, gated by writer progress and feeder back-pressure.
module mem_bank_b_read_gen
   import mem_bank_b_read_gen_pkg::*;
#(
   parameter int ARRAY_WIDTH          = 4,
   parameter int BUFFER_ADDRESS_WIDTH = 10
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            start_i,
   input  logic [DIM_W-1:0]                m,
   input  logic [DIM_W-1:0]                n,
   input  logic [DIM_W-1:0]                p,
   input  logic [DIM_W-1:0]                wr_count_i,
   output logic                            rd_en_o,
   output logic [BUFFER_ADDRESS_WIDTH-1:0] addr_o,
   output logic                            valid_o,
   input  logic                            ready_i,
   output logic                            last_k_o,
   output logic                            busy_o,
   output logic                            done_o,
   output logic                            cfg_err_o
);

   localparam int AW = BUFFER_ADDRESS_WIDTH;

   rd_state_e        r_state, w_state_next;
   logic [DIM_W-1:0] r_n, r_pt, r_mt;
   logic [AW-1:0]    r_addr;
   logic             r_valid, r_last, r_done, r_err;
   logic             w_done_next, w_err_next, w_valid_next;
   logic             w_rd_en, w_k_wrap, w_j_wrap, w_i_wrap;
   logic             w_empty, w_too_big;
   logic [32:0]      w_words;

   assign w_words   = 33'(r_n) * 33'(r_pt);
   assign w_empty   = (r_n == '0) || (r_pt == '0) || (r_mt == '0);
   assign w_too_big = w_words > (33'd1 << AW);

   // A read needs the word already written and a free output slot (empty or being taken).
   assign w_rd_en      = (r_state == ST_STREAM) && (32'(wr_count_i) > 32'(r_addr)) && (!r_valid || ready_i);
   assign w_valid_next = w_rd_en || (r_valid && !ready_i);

   mem_bank_b_read_gen_tile_counter #(.W(DIM_W)) u_cnt_k (
      .clk(clk), .reset_n(reset_n), .clr(start_i), .en(w_rd_en), .limit(r_n), .wrap_o(w_k_wrap));
   mem_bank_b_read_gen_tile_counter #(.W(DIM_W)) u_cnt_j (
      .clk(clk), .reset_n(reset_n), .clr(start_i), .en(w_k_wrap), .limit(r_pt), .wrap_o(w_j_wrap));
   mem_bank_b_read_gen_tile_counter #(.W(DIM_W)) u_cnt_i (
      .clk(clk), .reset_n(reset_n), .clr(start_i), .en(w_j_wrap), .limit(r_mt), .wrap_o(w_i_wrap));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_done_next  = 1'b0;
      w_err_next   = 1'b0;
      if (start_i) begin
         w_state_next = ST_CHECK;
      end else begin
         case (r_state)
            ST_CHECK: begin
               if (w_empty) begin
                  w_done_next  = 1'b1;
                  w_state_next = ST_IDLE;
               end else if (w_too_big) begin
                  w_done_next  = 1'b1;
                  w_err_next   = 1'b1;
                  w_state_next = ST_IDLE;
               end else begin
                  w_state_next = ST_STREAM;
               end
            end
            ST_STREAM: begin
               if (w_i_wrap) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
               if (!r_valid || ready_i) begin
                  w_done_next  = 1'b1;
                  w_state_next = ST_IDLE;
               end
            end
            default: w_state_next = r_state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_n     <= '0;
         r_pt    <= '0;
         r_mt    <= '0;
         r_addr  <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= w_done_next;
         r_err  <= w_err_next;
         if (start_i) begin
            r_n     <= n;
            r_pt    <= floor_tiles(p, ARRAY_WIDTH);
            r_mt    <= ceil_tiles(m, ARRAY_WIDTH);
            r_addr  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
         end else begin
            r_valid <= w_valid_next;
            r_last  <= w_rd_en ? w_k_wrap : (w_valid_next && r_last);
            // Column tiles are contiguous, so +1 covers the k wrap; only a j wrap rewinds.
            if (w_rd_en) r_addr <= w_j_wrap ? '0 : r_addr + AW'(1);
         end
      end
   end

   assign rd_en_o   = w_rd_en;
   assign addr_o    = r_addr;
   assign valid_o   = r_valid;
   assign last_k_o  = r_last;
   assign busy_o    = (r_state != ST_IDLE);
   assign done_o    = r_done;
   assign cfg_err_o = r_err;

endmodule

// File: tb/tb_mem_bank_b_read_gen.sv
// Self-checking bench: pass-level table, hand corner sequences and randomized traffic
// against a queue-based model of the expected read stream.
`timescale 1ns/1ps
module tb_mem_bank_b_read_gen;

   localparam int AWID = 4;
   localparam int BAW  = 10;

   logic           clk = 1'b0;
   logic           reset_n, start_i, ready_i;
   logic [15:0]    m, n, p, wr_count_i;
   logic           rd_en_o, valid_o, last_k_o, busy_o, done_o, cfg_err_o;
   logic [BAW-1:0] addr_o;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 0;

   always #5 clk = ~clk;

   mem_bank_b_read_gen #(.ARRAY_WIDTH(AWID), .BUFFER_ADDRESS_WIDTH(BAW)) dut (
      .clk(clk), .reset_n(reset_n), .start_i(start_i), .m(m), .n(n), .p(p),
      .wr_count_i(wr_count_i), .rd_en_o(rd_en_o), .addr_o(addr_o), .valid_o(valid_o),
      .ready_i(ready_i), .last_k_o(last_k_o), .busy_o(busy_o), .done_o(done_o),
      .cfg_err_o(cfg_err_o));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: 0 idle, 1 config check, 2 streaming/draining; the expected read
   // stream is a queue of (address, last-of-column) built straight from the loop nest.
   int          mph = 0;
   bit          mvld, mlast, mdone, merr;
   int unsigned qa[$];
   bit          ql[$];
   longint      mn, mpt, mmt;

   function automatic bit exp_rd();
      return (mph == 2) && (qa.size() > 0) && (int'(wr_count_i) > int'(qa[0])) && (!mvld || ready_i);
   endfunction

   task automatic model_step(input bit erd);
      if (!reset_n) begin
         mph = 0; mvld = 0; mlast = 0; mdone = 0; merr = 0;
         qa.delete(); ql.delete();
      end else if (start_i) begin
         mn = n; mpt = p / AWID; mmt = (m + AWID - 1) / AWID;
         mph = 1; mvld = 0; mlast = 0; mdone = 0; merr = 0;
         qa.delete(); ql.delete();
      end else begin
         mdone = 0; merr = 0;
         if (mph == 1) begin
            if (mn == 0 || mpt == 0 || mmt == 0) begin
               mdone = 1; mph = 0;
            end else if (mn * mpt > (64'd1 << BAW)) begin
               mdone = 1; merr = 1; mph = 0;
            end else begin
               for (longint i = 0; i < mmt; i++)
                  for (longint j = 0; j < mpt; j++)
                     for (longint k = 0; k < mn; k++) begin
                        qa.push_back(int'(j * mn + k));
                        ql.push_back(k == mn - 1);
                     end
               mph = 2;
            end
         end else if (mph == 2) begin
            if (qa.size() == 0) begin
               if (!mvld || ready_i) begin
                  mdone = 1; mvld = 0; mlast = 0; mph = 0;
               end
            end else if (erd) begin
               mlast = ql[0]; mvld = 1;
               void'(qa.pop_front()); void'(ql.pop_front());
            end else if (ready_i) begin
               mvld = 0; mlast = 0;
            end
         end
      end
   endtask

   // Inputs change on negedge; compare and advance the model 2ns later.
   always @(negedge clk) begin
      bit erd;
      #2;
      erd = exp_rd();
      if (chk_en) begin
         chk("model.busy", busy_o, mph != 0);
         chk("model.valid", valid_o, mvld);
         chk("model.last_k", last_k_o, mlast);
         chk("model.done", done_o, mdone);
         chk("model.cfg_err", cfg_err_o, merr);
         chk("model.rd_en", rd_en_o, erd);
         if (erd) chk("model.addr", addr_o, qa[0]);
      end
      model_step(erd);
   end

   task automatic go(input int mm, input int nn, input int pp);
      @(negedge clk);
      m = 16'(mm); n = 16'(nn); p = 16'(pp); start_i = 1;
      @(negedge clk);
      start_i = 0;
   endtask

   task automatic wait_done(input int budget, input string nm);
      bit seen = 0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk); #1;
         if (done_o) begin seen = 1; break; end
      end
      chk({nm, ".done_seen"}, seen, 1);
   endtask

   typedef struct {
      int m, n, p;
      int exp_reads;
      bit exp_err;
      int exp_lat;
   } vec_t;

   vec_t tbl[10];

   initial begin
      int reads, lat, early, cnt;
      bit err, found;
      tbl[0] = '{4, 3, 8, 6, 0, 9};
      tbl[1] = '{8, 2, 4, 4, 0, 7};
      tbl[2] = '{5, 4, 12, 24, 0, 27};
      tbl[3] = '{3, 1, 4, 1, 0, 4};
      tbl[4] = '{4, 600, 8, 0, 1, 2};
      tbl[5] = '{4, 0, 8, 0, 0, 2};
      tbl[6] = '{4, 3, 3, 0, 0, 2};
      tbl[7] = '{0, 3, 8, 0, 0, 2};
      tbl[8] = '{1, 512, 8, 1024, 0, 1027};
      tbl[9] = '{1, 513, 8, 0, 1, 2};

      reset_n = 0; start_i = 0; ready_i = 1; m = 0; n = 0; p = 0; wr_count_i = 0;
      repeat (3) @(negedge clk);
      chk_en = 1;
      #1;
      chk("reset.busy", busy_o, 0);
      chk("reset.addr", addr_o, 0);
      chk("reset.valid", valid_o, 0);
      chk("reset.done", done_o, 0);
      @(negedge clk); reset_n = 1;

      // Pass-level table: reads issued, error flag and start-to-done latency.
      foreach (tbl[t]) begin
         @(negedge clk);
         m = 16'(tbl[t].m); n = 16'(tbl[t].n); p = 16'(tbl[t].p);
         start_i = 1; ready_i = 1; wr_count_i = 16'hFFFF;
         reads = 0; err = 0; lat = -1;
         for (int c = 1; c <= 1200; c++) begin
            @(negedge clk); start_i = 0; #1;
            if (rd_en_o) reads++;
            if (cfg_err_o) err = 1;
            if (done_o) begin lat = c; break; end
         end
         $display("vec %0d m=%0d n=%0d p=%0d reads=%0d err=%0d lat=%0d",
                  t, tbl[t].m, tbl[t].n, tbl[t].p, reads, err, lat);
         chk($sformatf("vec%0d.reads", t), reads, tbl[t].exp_reads);
         chk($sformatf("vec%0d.err", t), err, tbl[t].exp_err);
         chk($sformatf("vec%0d.lat", t), lat, tbl[t].exp_lat);
      end

      // Writer lagging: no reads until data is written, then 0,1,0,1.
      wr_count_i = 0; ready_i = 1;
      go(8, 2, 4);
      early = 0; reads = 0; found = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         wr_count_i = (c < 6) ? 16'd0 : (c < 9) ? 16'd1 : 16'd2;
         #1;
         if (c < 6 && rd_en_o) early++;
         if (rd_en_o) reads++;
         if (done_o) begin found = 1; break; end
      end
      $display("lag seq reads=%0d early=%0d done=%0d", reads, early, found);
      chk("lag.early_reads", early, 0);
      chk("lag.reads", reads, 4);
      chk("lag.done", found, 1);

      // Back-pressure while word 1 is presented.
      wr_count_i = 16'hFFFF; ready_i = 1;
      go(4, 3, 8);
      found = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk); #1;
         if (valid_o && addr_o == 2) begin found = 1; break; end
      end
      chk("stall.reached", found, 1);
      ready_i = 0;
      for (int c = 0; c < 3; c++) begin
         if (c > 0) begin @(negedge clk); #1; end
         #1;
         chk("stall.rd_en", rd_en_o, 0);
         chk("stall.addr", addr_o, 2);
         chk("stall.valid", valid_o, 1);
      end
      @(negedge clk); ready_i = 1;
      wait_done(20, "stall");
      $display("stall seq complete");

      // Restart mid-stream at address 4.
      go(4, 3, 8);
      found = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk); #1;
         if (addr_o == 4) begin found = 1; break; end
      end
      chk("abort.reached", found, 1);
      m = 8; n = 2; p = 4; start_i = 1;
      @(negedge clk); start_i = 0; #1;
      chk("abort.valid", valid_o, 0);
      chk("abort.addr", addr_o, 0);
      chk("abort.busy", busy_o, 1);
      wait_done(40, "abort");
      $display("abort seq complete");

      // Reset mid-pass: everything clears, no done.
      go(4, 3, 8);
      repeat (3) @(negedge clk);
      reset_n = 0;
      @(negedge clk); reset_n = 1; #1;
      chk("rst.busy", busy_o, 0);
      chk("rst.valid", valid_o, 0);
      chk("rst.rd_en", rd_en_o, 0);
      chk("rst.addr", addr_o, 0);
      chk("rst.last_k", last_k_o, 0);
      cnt = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk); #1;
         if (done_o) cnt++;
      end
      chk("rst.no_done", cnt, 0);
      $display("reset seq complete");

      // Randomized traffic; the model checks every cycle.
      for (int t = 0; t < 40; t++) begin
         int mm, nn, pp;
         bit do_abort;
         if ($urandom_range(0, 9) == 0) begin
            mm = $urandom_range(1, 4); nn = $urandom_range(250, 260); pp = 16;
         end else begin
            mm = $urandom_range(0, 12); nn = $urandom_range(0, 6); pp = $urandom_range(0, 20);
         end
         do_abort = ($urandom_range(0, 7) == 0);
         wr_count_i = 16'($urandom_range(0, 2));
         go(mm, nn, pp);
         found = 0;
         for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            ready_i = ($urandom_range(0, 9) < 7);
            if (wr_count_i < 16'hFFF0) wr_count_i = wr_count_i + 16'($urandom_range(0, 2));
            if (do_abort && c == 5) begin
               m = 16'($urandom_range(1, 8)); n = 16'($urandom_range(1, 5)); p = 16'($urandom_range(4, 12));
               start_i = 1;
            end else begin
               start_i = 0;
            end
            #1;
            if (done_o) begin found = 1; break; end
         end
         start_i = 0;
         $display("rand %0d m=%0d n=%0d p=%0d abort=%0d done=%0d", t, mm, nn, pp, do_abort, found);
         chk($sformatf("rand%0d.done", t), found, 1);
      end

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
